// File: rtl/module_act_lut_xn.sv
// N-lane activation LUT with active/shadow table banks and a frame-aligned bank swap.
// Ports: clk, rst (sync, active-high); loader ld_start/ld_valid/ld_data/ld_ready/ld_done,
//   bank_sel; lookup in_valid/in_last/in_data -> out_valid/out_data, 2-cycle latency.
//   Optional macro ACT_LUT_BYPASS_EN adds input bypass (beat passes through unmodified).

module com_simple_dual_port_ram #(
  parameter int    WIDTH     = 8,
  parameter int    ADDR_BIT  = 9,
  parameter int    DEPTH     = 512,
  parameter string RAM_STYLE = "distributed"
) (
  input  logic                clk,
  input  logic                wr_en_i,
  input  logic [ADDR_BIT-1:0] wr_addr_i,
  input  logic [WIDTH-1:0]    wr_data_i,
  input  logic                rd_en_i,
  input  logic [ADDR_BIT-1:0] rd_addr_i,
  output logic [WIDTH-1:0]    rd_data_o
);

  (* ram_style = RAM_STYLE *)
  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
    if (rd_en_i) rd_data_o <= mem_q[rd_addr_i];
  end

endmodule

module module_act_lut_xn #(
  parameter int    LANES         = 8,
  parameter int    DW            = 8,
  parameter string RAM_STYLE_VAL = "distributed"
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ld_start,
  input  logic                ld_valid,
  input  logic [DW-1:0]       ld_data,
  output logic                ld_ready,
  output logic                ld_done,
  output logic                bank_sel,
  input  logic                in_valid,
  input  logic                in_last,
  input  logic [LANES*DW-1:0] in_data,
`ifdef ACT_LUT_BYPASS_EN
  input  logic                bypass,
`endif
  output logic                out_valid,
  output logic [LANES*DW-1:0] out_data
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_ARMED
  } state_e;

  state_e            state_q, state_d;
  logic [DW-1:0]     wr_addr_q, wr_addr_d;
  logic              bank_q, bank_d;
  logic              wr_en;
  logic              v1_q;
  logic              out_valid_q;
  logic [LANES*DW-1:0] out_data_q;
  logic [LANES*DW-1:0] rd_cat;
  logic [LANES*DW-1:0] res;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      wr_addr_q <= '0;
      bank_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_addr_q <= wr_addr_d;
      bank_q    <= bank_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    wr_addr_d = wr_addr_q;
    bank_d    = bank_q;
    ld_ready  = 1'b0;
    ld_done   = 1'b0;
    wr_en     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (ld_start) begin
          state_d   = S_LOAD;
          wr_addr_d = '0;
        end
      end
      S_LOAD: begin
        ld_ready = 1'b1;
        if (ld_valid) begin
          wr_en = 1'b1;
          if (wr_addr_q == '1) begin
            state_d = S_ARMED;
          end else begin
            wr_addr_d = wr_addr_q + DW'(1);
          end
        end
      end
      S_ARMED: begin
        // swap only between frames; the closing beat still reads the old bank
        if (!in_valid || in_last) begin
          bank_d  = ~bank_q;
          ld_done = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bank_sel = bank_q;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    com_simple_dual_port_ram #(
      .WIDTH    (DW),
      .ADDR_BIT (DW + 1),
      .DEPTH    (2 ** (DW + 1)),
      .RAM_STYLE(RAM_STYLE_VAL)
    ) u_ram (
      .clk      (clk),
      .wr_en_i  (wr_en),
      .wr_addr_i({~bank_q, wr_addr_q}),
      .wr_data_i(ld_data),
      .rd_en_i  (in_valid),
      .rd_addr_i({bank_q, in_data[i*DW +: DW]}),
      .rd_data_o(rd_cat[i*DW +: DW])
    );
  end

`ifdef ACT_LUT_BYPASS_EN
  logic                byp1_q;
  logic [LANES*DW-1:0] din1_q;

  // raw beat travels alongside the RAM read stage
  always_ff @(posedge clk) begin
    if (rst) begin
      byp1_q <= 1'b0;
      din1_q <= '0;
    end else if (in_valid) begin
      byp1_q <= bypass;
      din1_q <= in_data;
    end
  end

  always_comb begin
    res = rd_cat;
    if (byp1_q) res = din1_q;
  end
`else
  always_comb begin
    res = rd_cat;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q        <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      v1_q        <= in_valid;
      out_valid_q <= v1_q;
      if (v1_q) out_data_q <= res;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_module_act_lut_xn.sv
// Bench for module_act_lut_xn: reference loader/bank model plus lookup scoreboard.
// Build with ACT_LUT_BYPASS_EN defined to exercise the bypass path as well.

module tb_module_act_lut_xn;

  localparam int LANES = 8;
  localparam int DW    = 8;
  localparam int W     = LANES * DW;
  localparam int N     = 2 ** DW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ld_start = 1'b0;
  logic          ld_valid = 1'b0;
  logic [DW-1:0] ld_data = '0;
  logic          ld_ready, ld_done, bank_sel;
  logic          in_valid = 1'b0;
  logic          in_last = 1'b0;
  logic [W-1:0]  in_data = '0;
  logic          out_valid;
  logic [W-1:0]  out_data;
`ifdef ACT_LUT_BYPASS_EN
  logic          bypass = 1'b0;
`endif

  int checks = 0;
  int failures = 0;
  int unsigned cyc = 0;
  bit mon_en = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  module_act_lut_xn #(
    .LANES(LANES),
    .DW   (DW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .ld_start (ld_start),
    .ld_valid (ld_valid),
    .ld_data  (ld_data),
    .ld_ready (ld_ready),
    .ld_done  (ld_done),
    .bank_sel (bank_sel),
    .in_valid (in_valid),
    .in_last  (in_last),
    .in_data  (in_data),
`ifdef ACT_LUT_BYPASS_EN
    .bypass   (bypass),
`endif
    .out_valid(out_valid),
    .out_data (out_data)
  );

  task automatic chk(input string tag, input logic [W-1:0] obs,
                     input logic [W-1:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, obs, exp);
    end
  endtask

  typedef struct {
    logic [W-1:0] data;
    int unsigned  due;
  } exp_t;

  typedef enum {M_IDLE, M_LOAD, M_ARMED} mst_e;

  exp_t          sbq[$];
  logic [DW-1:0] tbl [2][N];
  mst_e          m_state = M_IDLE;
  int            m_addr = 0;
  logic          m_bank = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    logic [W-1:0] ev;
    logic [DW-1:0] ln;
    bit byp;
    if (mon_en) begin
      chk("ld_ready", W'(ld_ready), W'(m_state == M_LOAD));
      chk("ld_done", W'(ld_done),
          W'((m_state == M_ARMED) && (!in_valid || in_last)));
      chk("bank_sel", W'(bank_sel), W'(m_bank));
      if (out_valid) begin
        if (sbq.size() == 0) begin
          chk("spurious_out", W'(1), W'(0));
        end else begin
          e = sbq.pop_front();
          chk("out_data", out_data, e.data);
          chk("latency", W'(cyc), W'(e.due));
        end
      end else if (sbq.size() > 0 && sbq[0].due <= cyc) begin
        chk("missing_out", W'(0), W'(1));
        void'(sbq.pop_front());
      end
    end
    if (rst) begin
      m_state = M_IDLE;
      m_addr  = 0;
      m_bank  = 1'b0;
      sbq.delete();
    end else begin
      if (in_valid) begin
        byp = 1'b0;
`ifdef ACT_LUT_BYPASS_EN
        byp = bypass;
`endif
        for (int i = 0; i < LANES; i++) begin
          ln = in_data[i*DW +: DW];
          ev[i*DW +: DW] = tbl[m_bank][ln];
        end
        if (byp) ev = in_data;
        e.data = ev;
        e.due  = cyc + 2;
        sbq.push_back(e);
      end
      case (m_state)
        M_IDLE: begin
          if (ld_start) begin
            m_state = M_LOAD;
            m_addr  = 0;
          end
        end
        M_LOAD: begin
          if (ld_valid) begin
            tbl[~m_bank][m_addr] = ld_data;
            if (m_addr == N - 1) m_state = M_ARMED;
            else m_addr++;
          end
        end
        default: begin
          if (!in_valid || in_last) begin
            m_bank  = ~m_bank;
            m_state = M_IDLE;
          end
        end
      endcase
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    in_valid = 1'b0;
    in_last  = 1'b0;
`ifdef ACT_LUT_BYPASS_EN
    bypass   = 1'b0;
`endif
  endtask

  task automatic beat(input logic [W-1:0] d, input bit last);
    in_valid = 1'b1;
    in_last  = last;
    in_data  = d;
    tick();
  endtask

  function automatic logic [W-1:0] rnd_w();
    return {$urandom, $urandom};
  endfunction

  function automatic logic [DW-1:0] fn(input int kind, input int k);
    logic [DW-1:0] x;
    logic signed [DW-1:0] s;
    x = k[DW-1:0];
    s = x;
    case (kind)
      0: return x[DW-1] ? DW'(s >>> 3) : x;
      1: return x;
      2: return ~x;
      3: return x ^ 8'h5A;
      default: return x + 8'd1;
    endcase
  endfunction

  task automatic load_table(input int kind, input bit gaps,
                            input bit busy, input int stop_at);
    int k;
    int guard;
    k = 0;
    guard = 0;
    ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
    while (k < N && k != stop_at && guard < 5000) begin
      ld_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      ld_data  = fn(kind, k);
      ld_start = (gaps && k >= 50 && k < 53);
      if (busy) begin
        in_valid = 1'b1;
        in_last  = 1'b0;
        in_data  = rnd_w();
      end
      if (ld_valid && ld_ready) k++;
      tick();
      guard++;
    end
    ld_valid = 1'b0;
    ld_start = 1'b0;
    if (guard >= 5000) chk("load_timeout", W'(0), W'(1));
  endtask

  task automatic rand_beats(input int n);
    for (int i = 0; i < n; i++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      in_last  = $urandom_range(0, 1);
      in_data  = rnd_w();
      tick();
    end
    idle_in();
  endtask

  initial begin
    logic [W-1:0] va;
    // reset
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    mon_en = 1'b1;
    chk("rst_out_valid", W'(out_valid), W'(0));
    chk("rst_ld_ready", W'(ld_ready), W'(0));
    chk("rst_ld_done", W'(ld_done), W'(0));
    chk("rst_bank_sel", W'(bank_sel), W'(0));
    chk("rst_out_data", out_data, W'(0));
    tick();

    // leaky table, quiet input: swap right after the last entry
    load_table(0, 1'b0, 1'b0, -1);
    #1;
    chk("leaky_done", W'(ld_done), W'(1));
    tick();
    chk("leaky_bank", W'(bank_sel), W'(1));
    va = rnd_w();
    va[31:0] = 32'h807FF010;
    beat(va, 1'b0);
    idle_in();
    tick();
    chk("leaky_vec", W'(out_data[31:0]), W'(32'hF07FFE10));
    tick();

`ifdef ACT_LUT_BYPASS_EN
    bypass = 1'b1;
    beat({LANES{8'hF0}}, 1'b0);
    bypass = 1'b0;
    beat({LANES{8'hF0}}, 1'b0);
    idle_in();
    chk("bypass_on", out_data, {LANES{8'hF0}});
    tick();
    chk("bypass_off", out_data, {LANES{8'hFE}});
    tick();
`endif

    // identity table with gaps, stray ld_start, traffic held through ARMED
    load_table(1, 1'b1, 1'b1, -1);
    for (int i = 0; i < 20; i++) beat(rnd_w(), 1'b0);
    va = 64'h807F00FF01C84087;
    beat(va, 1'b1);
    beat(va, 1'b0);
    idle_in();
    chk("armed_old_tbl", out_data, 64'hF07F00FF01F940F0);
    tick();
    chk("armed_new_tbl", out_data, va);
    chk("armed_bank", W'(bank_sel), W'(0));
    tick();
    rand_beats(30);

    // inverted table into bank 1
    load_table(2, 1'b0, 1'b0, -1);
    tick();
    rand_beats(40);
    repeat (3) tick();

    // reset part-way through a load
    load_table(4, 1'b0, 1'b0, 100);
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk("midrst_bank", W'(bank_sel), W'(0));
    chk("midrst_ready", W'(ld_ready), W'(0));
    tick();
    rand_beats(20);
    load_table(3, 1'b1, 1'b0, -1);
    tick();
    chk("reload_bank", W'(bank_sel), W'(1));
    rand_beats(40);

    repeat (4) tick();
    chk("drain", W'(sbq.size()), W'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
